// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - timing descriptors, mode constants and period helpers for the VGA raster timer
package vga_pkg;

  typedef struct packed {
    logic [15:0] h_pixels;
    logic [15:0] h_fp;
    logic [15:0] h_pulse;
    logic [15:0] h_bp;
    logic        h_pol;
    logic [15:0] v_pixels;
    logic [15:0] v_fp;
    logic [15:0] v_pulse;
    logic [15:0] v_bp;
    logic        v_pol;
  } timing_t;

  localparam timing_t VGA_640x480 = '{
    h_pixels: 16'd640, h_fp: 16'd16, h_pulse: 16'd96, h_bp: 16'd48, h_pol: 1'b0,
    v_pixels: 16'd480, v_fp: 16'd10, v_pulse: 16'd2,  v_bp: 16'd33, v_pol: 1'b0
  };

  localparam timing_t VGA_800x600_40M = '{
    h_pixels: 16'd800, h_fp: 16'd40, h_pulse: 16'd128, h_bp: 16'd88, h_pol: 1'b1,
    v_pixels: 16'd600, v_fp: 16'd1,  v_pulse: 16'd4,   v_bp: 16'd23, v_pol: 1'b1
  };

  localparam timing_t TINY_8x4 = '{
    h_pixels: 16'd8, h_fp: 16'd2, h_pulse: 16'd3, h_bp: 16'd1, h_pol: 1'b1,
    v_pixels: 16'd4, v_fp: 16'd1, v_pulse: 16'd1, v_bp: 16'd1, v_pol: 1'b1
  };

  function automatic int h_period(timing_t t);
    return int'(t.h_pixels) + int'(t.h_fp) + int'(t.h_pulse) + int'(t.h_bp);
  endfunction

  function automatic int v_period(timing_t t);
    return int'(t.v_pixels) + int'(t.v_fp) + int'(t.v_pulse) + int'(t.v_bp);
  endfunction

  function automatic int h_sync_start(timing_t t);
    return int'(t.h_pixels) + int'(t.h_fp);
  endfunction

  function automatic int h_sync_end(timing_t t);
    return h_sync_start(t) + int'(t.h_pulse);
  endfunction

  function automatic int v_sync_start(timing_t t);
    return int'(t.v_pixels) + int'(t.v_fp);
  endfunction

  function automatic int v_sync_end(timing_t t);
    return v_sync_start(t) + int'(t.v_pulse);
  endfunction

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // One counter width serves both axes of both modes.
  function automatic int cnt_width(timing_t a, timing_t b);
    int m;
    m = max2(max2(h_period(a), v_period(a)), max2(h_period(b), v_period(b)));
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic bit fields_ok(timing_t t);
    return (t.h_pixels >= 16'd1) && (t.h_fp >= 16'd1) && (t.h_pulse >= 16'd1) &&
           (t.h_bp >= 16'd1) && (t.v_pixels >= 16'd1) && (t.v_fp >= 16'd1) &&
           (t.v_pulse >= 16'd1) && (t.v_bp >= 16'd1);
  endfunction

  function automatic bit fits(timing_t t, int col_width, int row_width);
    return (int'(t.h_pixels) <= (1 << col_width)) && (int'(t.v_pixels) <= (1 << row_width));
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - resettable shift register with a per-bit reset value
module vga_delay_line #(
  parameter int           W       = 1,
  parameter int           DEPTH   = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] data,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= data;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - two-mode VGA raster timer with a fetch port leading the display port
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int      COL_WIDTH = 10,
  parameter int      ROW_WIDTH = 9,
  parameter timing_t MODE_A    = VGA_640x480,
  parameter timing_t MODE_B    = VGA_640x480,
  parameter int      LEAD      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode_sel,
  output logic                 mode_active,
  output logic                 fetch_valid,
  output logic [COL_WIDTH-1:0] fetch_col,
  output logic [ROW_WIDTH-1:0] fetch_row,
  output logic                 h_sync,
  output logic                 v_sync,
  output logic                 disp_ena,
  output logic [COL_WIDTH-1:0] col,
  output logic [ROW_WIDTH-1:0] row,
  output logic                 end_line,
  output logic                 end_frame,
  output logic                 start_frame
);

  if (LEAD < 1 || LEAD > 8) begin : g_bad_lead
    $error("vga_timing_gen: LEAD must be within 1..8");
  end
  if (!fields_ok(MODE_A) || !fields_ok(MODE_B)) begin : g_bad_fields
    $error("vga_timing_gen: every pixel/porch/pulse field must be at least 1");
  end
  if (!fits(MODE_A, COL_WIDTH, ROW_WIDTH) || !fits(MODE_B, COL_WIDTH, ROW_WIDTH)) begin : g_bad_fit
    $error("vga_timing_gen: visible area exceeds COL_WIDTH/ROW_WIDTH");
  end

  localparam int CW = cnt_width(MODE_A, MODE_B);
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t A_H_PIX  = cnt_t'(int'(MODE_A.h_pixels));
  localparam cnt_t A_H_LV   = cnt_t'(int'(MODE_A.h_pixels) - 1);
  localparam cnt_t A_H_SS   = cnt_t'(h_sync_start(MODE_A));
  localparam cnt_t A_H_SE   = cnt_t'(h_sync_end(MODE_A));
  localparam cnt_t A_H_LAST = cnt_t'(h_period(MODE_A) - 1);
  localparam cnt_t A_V_PIX  = cnt_t'(int'(MODE_A.v_pixels));
  localparam cnt_t A_V_LV   = cnt_t'(int'(MODE_A.v_pixels) - 1);
  localparam cnt_t A_V_SS   = cnt_t'(v_sync_start(MODE_A));
  localparam cnt_t A_V_SE   = cnt_t'(v_sync_end(MODE_A));
  localparam cnt_t A_V_LAST = cnt_t'(v_period(MODE_A) - 1);

  localparam cnt_t B_H_PIX  = cnt_t'(int'(MODE_B.h_pixels));
  localparam cnt_t B_H_LV   = cnt_t'(int'(MODE_B.h_pixels) - 1);
  localparam cnt_t B_H_SS   = cnt_t'(h_sync_start(MODE_B));
  localparam cnt_t B_H_SE   = cnt_t'(h_sync_end(MODE_B));
  localparam cnt_t B_H_LAST = cnt_t'(h_period(MODE_B) - 1);
  localparam cnt_t B_V_PIX  = cnt_t'(int'(MODE_B.v_pixels));
  localparam cnt_t B_V_LV   = cnt_t'(int'(MODE_B.v_pixels) - 1);
  localparam cnt_t B_V_SS   = cnt_t'(v_sync_start(MODE_B));
  localparam cnt_t B_V_SE   = cnt_t'(v_sync_end(MODE_B));
  localparam cnt_t B_V_LAST = cnt_t'(v_period(MODE_B) - 1);

  typedef struct packed {
    logic                 vis;
    logic [COL_WIDTH-1:0] col;
    logic [ROW_WIDTH-1:0] row;
    logic                 h_sync;
    logic                 v_sync;
    logic                 end_line;
    logic                 end_frame;
    logic                 start_frame;
  } stage_t;

  localparam int SW = $bits(stage_t);
  localparam stage_t STAGE_RST = '{
    vis: 1'b0, col: '0, row: '0,
    h_sync: ~MODE_A.h_pol, v_sync: ~MODE_A.v_pol,
    end_line: 1'b0, end_frame: 1'b0, start_frame: 1'b0
  };

  cnt_t h_cnt, v_cnt;
  logic mode;

  cnt_t h_pix, h_lv, h_ss, h_se, h_last;
  cnt_t v_pix, v_lv, v_ss, v_se, v_last;
  logic h_pol, v_pol;

  always_comb begin
    h_pix  = A_H_PIX;  h_lv = A_H_LV; h_ss = A_H_SS; h_se = A_H_SE; h_last = A_H_LAST;
    v_pix  = A_V_PIX;  v_lv = A_V_LV; v_ss = A_V_SS; v_se = A_V_SE; v_last = A_V_LAST;
    h_pol  = MODE_A.h_pol;
    v_pol  = MODE_A.v_pol;
    if (mode) begin
      h_pix = B_H_PIX; h_lv = B_H_LV; h_ss = B_H_SS; h_se = B_H_SE; h_last = B_H_LAST;
      v_pix = B_V_PIX; v_lv = B_V_LV; v_ss = B_V_SS; v_se = B_V_SE; v_last = B_V_LAST;
      h_pol = MODE_B.h_pol;
      v_pol = MODE_B.v_pol;
    end
  end

  logic line_wrap, frame_last_line;
  assign line_wrap       = (h_cnt == h_last);
  assign frame_last_line = (v_cnt == v_last);

  // The mode register only loads on the frame wrap, so a frame always runs with one timing set.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
      mode  <= 1'b0;
    end else if (line_wrap) begin
      h_cnt <= '0;
      if (frame_last_line) begin
        v_cnt <= '0;
        mode  <= mode_sel;
      end else begin
        v_cnt <= v_cnt + cnt_t'(1);
      end
    end else begin
      h_cnt <= h_cnt + cnt_t'(1);
    end
  end

  logic h_vis, v_vis;
  assign h_vis       = (h_cnt < h_pix);
  assign v_vis       = (v_cnt < v_pix);
  assign fetch_valid = h_vis && v_vis;
  assign fetch_col   = COL_WIDTH'(h_cnt);
  assign fetch_row   = ROW_WIDTH'(v_cnt);
  assign mode_active = mode;

  logic [COL_WIDTH-1:0] last_col;
  logic [ROW_WIDTH-1:0] last_row;
  stage_t fetch_stage, disp_stage;
  logic [SW-1:0] disp_bits;

  // Coordinates are held here, ahead of the pipeline, so the pipeline itself stays a plain shift.
  always_comb begin
    fetch_stage.vis         = fetch_valid;
    fetch_stage.col         = fetch_valid ? fetch_col : last_col;
    fetch_stage.row         = fetch_valid ? fetch_row : last_row;
    fetch_stage.h_sync      = (h_cnt >= h_ss && h_cnt < h_se) ? h_pol : ~h_pol;
    fetch_stage.v_sync      = (v_cnt >= v_ss && v_cnt < v_se) ? v_pol : ~v_pol;
    fetch_stage.end_line    = v_vis && (h_cnt == h_pix);
    fetch_stage.end_frame   = (h_cnt == h_lv) && (v_cnt == v_lv);
    fetch_stage.start_frame = (h_cnt == '0) && (v_cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_col <= '0;
      last_row <= '0;
    end else begin
      last_col <= fetch_stage.col;
      last_row <= fetch_stage.row;
    end
  end

  vga_delay_line #(
    .W       (SW),
    .DEPTH   (LEAD),
    .RST_VAL (STAGE_RST)
  ) u_disp_pipe (
    .clk   (clk),
    .reset (reset),
    .data  (fetch_stage),
    .q     (disp_bits)
  );

  assign disp_stage  = stage_t'(disp_bits);
  assign disp_ena    = disp_stage.vis;
  assign col         = disp_stage.col;
  assign row         = disp_stage.row;
  assign h_sync      = disp_stage.h_sync;
  assign v_sync      = disp_stage.v_sync;
  assign end_line    = disp_stage.end_line;
  assign end_frame   = disp_stage.end_frame;
  assign start_frame = disp_stage.start_frame;

endmodule
